load_hazard_ctrl: RTL

Parametrised hazard controller for the five-stage RISC-V pipeline, sitting between the ID and EX stages. It detects load-use hazards against a configurable load latency and holds the front end for as many cycles as the latency requires. It squashes the IF/ID and ID/EX registers on a taken branch and freezes the whole pipeline while data memory is busy. Outputs drive the PC write enable, the IF/ID write/flush controls, the ID/EX control-mux select and a global hold.

---
 rtl/load_hazard_ctrl_if.sv | 42 ++++
 rtl/load_hazard_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/load_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : load_hazard_ctrl_if
// Brief   : ID/EX hazard-controller signal bundle (optional HAZARD_STALL_CNT_EN)
// Revision: 1.0
// ============================================================================
interface load_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] idex_rd;
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              idex_memread;
  logic              branch_taken;
  logic              mem_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_mux_out;
  logic              pipe_hold;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_count;
`endif

  modport master (
    output idex_rd, ifid_rs1, ifid_rs2, idex_memread, branch_taken, mem_busy,
`ifdef HAZARD_STALL_CNT_EN
    input  stall_count,
`endif
    input  pc_write, ifid_write, ifid_flush, idex_mux_out, pipe_hold
  );

  modport slave (
    input  idex_rd, ifid_rs1, ifid_rs2, idex_memread, branch_taken, mem_busy,
`ifdef HAZARD_STALL_CNT_EN
    output stall_count,
`endif
    output pc_write, ifid_write, ifid_flush, idex_mux_out, pipe_hold
  );
endinterface
`default_nettype wire

// File: rtl/load_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : load_hazard_ctrl
// Brief   : Load-use stall / branch flush / memory freeze control between ID
//           and EX. Macro HAZARD_STALL_CNT_EN adds the stall_count counter.
// Revision: 1.0
// ============================================================================
module load_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  load_hazard_ctrl_if.slave bus
);

  localparam int c_RW = $clog2(LOAD_LAT + 1);
  localparam logic [0:0] c_ST_RUN    = 1'b0;
  localparam logic [0:0] c_ST_LSTALL = 1'b1;
  localparam logic [c_RW-1:0] c_REM_INIT = c_RW'(LOAD_LAT - 1);
  localparam bit c_CFG_OK = (LOAD_LAT >= 1) && (LOAD_LAT <= 7) && (CNT_W >= 1);

  logic [0:0]        state_q, state_d;
  logic [c_RW-1:0]   rem_q, rem_d;
  logic [REG_AW-1:0] w_rd;
  logic              w_hit;
  logic              w_pc_write, w_ifid_write, w_ifid_flush, w_idex_mux, w_pipe_hold;

  assign w_rd  = bus.idex_rd;
  // Out-of-range LOAD_LAT settings never raise a stall.
  assign w_hit = c_CFG_OK && bus.idex_memread && (w_rd != '0) &&
                 ((w_rd == bus.ifid_rs1) || (w_rd == bus.ifid_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_ST_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (bus.mem_busy) begin
      state_d = state_q;
      rem_d   = rem_q;
    end else if (bus.branch_taken) begin
      state_d = c_ST_RUN;
      rem_d   = '0;
    end else if (state_q == c_ST_LSTALL) begin
      rem_d = rem_q - c_RW'(1);
      if (rem_q == c_RW'(1)) state_d = c_ST_RUN;
    end else if (w_hit && (LOAD_LAT > 1)) begin
      state_d = c_ST_LSTALL;
      rem_d   = c_REM_INIT;
    end
  end

  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_mux   = 1'b1;
    w_pipe_hold  = 1'b0;
    if (bus.mem_busy) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_pipe_hold  = 1'b1;
    end else if (bus.branch_taken) begin
      w_ifid_flush = 1'b1;
      w_idex_mux   = 1'b0;
    end else if ((state_q == c_ST_LSTALL) || w_hit) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_mux   = 1'b0;
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.ifid_write   = w_ifid_write;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_mux_out = w_idex_mux;
  assign bus.pipe_hold    = w_pipe_hold;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Counts load stalls and memory freezes alike; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else if (!w_pc_write) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign bus.stall_count = stall_cnt_q;
`endif

endmodule
`default_nettype wire
